// File: rtl/win_cmd_gen.sv
// win_cmd_gen: turns seven raw board buttons into the WIN_CTRL_CMD vector
// for the cursor/window controller.
//   clk              system clock
//   rst              asynchronous active-low reset
//   btn_up/down/left/right, btn_zin, btn_zout, btn_mode
//                    raw active-high asynchronous buttons
//   win_ctrl_cmd     registered command vector: single-cycle move/zoom
//                    pulses plus the M_MODE level
// Build option: WIN_CMD_AUTOREPEAT_EN enables hold/auto-repeat on the four
// direction keys; without it they pulse once per press like the zoom keys.
// Bit positions come from the defines.v macros; fallbacks are provided here
// so the file stands alone.

`ifndef M_UP
`define M_UP 0
`endif
`ifndef M_DOWN
`define M_DOWN 1
`endif
`ifndef M_LEFT
`define M_LEFT 2
`endif
`ifndef M_RIGHT
`define M_RIGHT 3
`endif
`ifndef Z_IN
`define Z_IN 4
`endif
`ifndef Z_OUT
`define Z_OUT 5
`endif
`ifndef M_MODE
`define M_MODE 6
`endif
`ifndef WIN_CTRL_CMD_W
`define WIN_CTRL_CMD_W 8
`endif

// Per-button 2-flop synchroniser plus debounce counter. o_db follows the
// synchronised input only after DEB_CYCLES consecutive differing samples.
module win_btn_deb #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_db
);
  logic [1:0]  r_sync;
  logic [15:0] r_cnt;
  logic        r_db;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_db   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_db)
        r_cnt <= '0;
      else if (r_cnt == DEB_CYCLES - 16'd1) begin
        r_db  <= r_sync[1];
        r_cnt <= '0;
      end else
        r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_db = r_db;
endmodule

module win_cmd_gen #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter logic [23:0] REP_DELAY  = 24'd5000000,
  parameter logic [23:0] REP_PERIOD = 24'd1500000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_left,
  input  logic                       btn_right,
  input  logic                       btn_zin,
  input  logic                       btn_zout,
  input  logic                       btn_mode,
  output logic [`WIN_CTRL_CMD_W-1:0] win_ctrl_cmd
);
  // key index: 0 up, 1 down, 2 left, 3 right, 4 zin, 5 zout, 6 mode
  localparam int NK = 7;

  logic [NK-1:0]              w_raw, w_db, r_db_q, w_press;
  logic [3:0]                 w_fire;
  logic [5:0]                 r_pulse;
  logic                       r_mode;
  logic                       w_zcol;
  logic [`WIN_CTRL_CMD_W-1:0] r_cmd, w_cmd;

  assign w_raw = {btn_mode, btn_zout, btn_zin, btn_right, btn_left, btn_down, btn_up};

  for (genvar k = 0; k < NK; k++) begin : g_deb
    win_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .i_raw (w_raw[k]),
      .o_db  (w_db[k])
    );
  end

  assign w_press = w_db & ~r_db_q;

`ifdef WIN_CMD_AUTOREPEAT_EN
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  for (genvar i = 0; i < 4; i++) begin : g_dir
    state_t      r_state, w_state_nxt;
    logic [23:0] r_rep, w_rep_nxt;
    logic        w_fire_i;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state <= S_IDLE;
        r_rep   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_rep   <= w_rep_nxt;
      end
    end

    // The counter is loaded on the pulse cycle, so a pulse fires when it
    // reads 1: that spaces pulses exactly REP_DELAY / REP_PERIOD apart.
    always_comb begin
      w_state_nxt = r_state;
      w_rep_nxt   = r_rep;
      w_fire_i    = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_press[i]) begin
            w_fire_i    = 1'b1;
            w_rep_nxt   = REP_DELAY;
            w_state_nxt = S_HOLD;
          end
        end
        S_HOLD, S_REPEAT: begin
          if (!w_db[i])
            w_state_nxt = S_IDLE;
          else if (r_rep == 24'd1) begin
            w_fire_i    = 1'b1;
            w_rep_nxt   = REP_PERIOD;
            w_state_nxt = S_REPEAT;
          end else
            w_rep_nxt = r_rep - 24'd1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    assign w_fire[i] = w_fire_i;
  end
`else
  logic w_unused_rep;
  assign w_unused_rep = ^{REP_DELAY, REP_PERIOD};
  assign w_fire       = w_press[3:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_db_q  <= '0;
      r_pulse <= '0;
      r_mode  <= 1'b0;
      r_cmd   <= '0;
    end else begin
      r_db_q  <= w_db;
      r_pulse <= {w_press[5:4], w_fire};
      if (w_press[6])
        r_mode <= ~r_mode;
      r_cmd   <= w_cmd;
    end
  end

  // Simultaneous zoom-in/zoom-out is ambiguous, so both are dropped.
  assign w_zcol = r_pulse[4] & r_pulse[5];

  always_comb begin
    w_cmd            = '0;
    w_cmd[`M_UP]     = r_pulse[0];
    w_cmd[`M_DOWN]   = r_pulse[1];
    w_cmd[`M_LEFT]   = r_pulse[2];
    w_cmd[`M_RIGHT]  = r_pulse[3];
    w_cmd[`Z_IN]     = r_pulse[4] & ~w_zcol;
    w_cmd[`Z_OUT]    = r_pulse[5] & ~w_zcol;
    w_cmd[`M_MODE]   = r_mode;
  end

  assign win_ctrl_cmd = r_cmd;
endmodule
